chinx_tick_ctrl: RTL

- CSR-programmable system tick scheduler. Replaces the fixed-divider tick with a period register, enable/mode control, a latched interrupt-pending bit with acknowledge handshake, and a saturating overrun counter.
- Sits between the CPU CSR/MMIO bus and the interrupt input of the core.
- Gives the kernel run-time control of tick rate, one-shot timeouts and missed-tick accounting.

---
 rtl/chinx_tick_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/chinx_tick_ctrl.sv
// chinx_tick_ctrl: CSR-programmable system tick with one-shot mode, latched interrupt and overrun counter
module chinx_tick_ctrl #(
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 10000,
    parameter int OVF_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic        csr_re,
    input  logic [1:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_rvalid,
    output logic        irq,
    input  logic        irq_ack
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d, os_q, os_d, ie_q, ie_d;
    logic [CNT_W-1:0] period_q, period_d, count_q, count_d;
    logic             pend_q, pend_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             irq_q, rvalid_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_ctrl, wr_per, wr_stat, tick, clr;

    assign wr_ctrl = csr_we && csr_addr == 2'd0;
    assign wr_per  = csr_we && csr_addr == 2'd1;
    assign wr_stat = csr_we && csr_addr == 2'd3;
    assign tick    = state_q == RUN && count_q == period_q;
    assign clr     = irq_ack || (wr_stat && csr_wdata[0]);

    assign csr_rdata  = rdata_q;
    assign csr_rvalid = rvalid_q;
    assign irq        = irq_q;

    // Run control: start/stop from CTRL writes, one-shot retirement, and a counter that never exceeds PERIOD
    always_comb begin
        state_d = state_q;
        en_d    = wr_ctrl ? csr_wdata[0] : en_q;
        os_d    = wr_ctrl ? csr_wdata[1] : os_q;
        ie_d    = wr_ctrl ? csr_wdata[2] : ie_q;
        count_d = '0;
        case (state_q)
            IDLE, DONE: state_d = wr_ctrl ? (csr_wdata[0] ? RUN : IDLE) : state_q;
            RUN: begin
                if (wr_ctrl && !csr_wdata[0]) state_d = IDLE;
                else if (tick && os_q && !wr_ctrl) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                end
                count_d = (wr_ctrl && !csr_wdata[0]) || tick || (wr_per && csr_wdata[CNT_W-1:0] <= count_q)
                        ? '0 : count_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending/overrun bookkeeping (a tick beats a clear for pending) and the pre-update read mux
    always_comb begin
        period_d = wr_per ? csr_wdata[CNT_W-1:0] : period_q;
        pend_d   = tick || (pend_q && !clr);
        ovf_d    = (wr_stat && csr_wdata[1]) ? '0
                 : (tick && pend_q && !clr && !(&ovf_q)) ? ovf_q + 1'b1 : ovf_q;
        rdata_d  = !csr_re             ? 32'd0
                 : csr_addr == 2'd0    ? {29'd0, ie_q, os_q, en_q}
                 : csr_addr == 2'd1    ? 32'(period_q)
                 : csr_addr == 2'd2    ? 32'(count_q)
                 :                       32'({ovf_q, 7'd0, pend_q});
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            os_q     <= 1'b0;
            ie_q     <= 1'b0;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            count_q  <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            os_q     <= os_d;
            ie_q     <= ie_d;
            period_q <= period_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            irq_q    <= pend_q & ie_q;
            rdata_q  <= rdata_d;
            rvalid_q <= csr_re;
        end
    end
endmodule
